core_csr_ctrl: RTL and testbench

- Sequencing stage directly upstream of the CSR register file.
- Accepts one CSR instruction at a time from the execute stage over a valid/ready handshake.
- Performs the read-modify-write for CSRRW/CSRRS/CSRRC and their immediate forms against the CSR file's read and write ports.
- Returns the old CSR value, or an illegal-access flag, to writeback over a second valid/ready handshake.

---
 rtl/core_csr_ctrl.sv | 145 ++++++++++++++
 tb/tb_core_csr_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_csr_ctrl.sv
// -----------------------------------------------------------------------------
// core_csr_ctrl
// Sequencing stage between the execute stage and the CSR register file.
// Takes one CSR instruction (CSRRW/RS/RC and immediate forms) at a time,
// reads the target CSR, computes the new value, optionally writes it back,
// and returns the old value (or an illegal-access flag) to writeback.
//
// Handshakes: a transfer happens on a channel in the cycle where both valid
// and ready are high at the rising clock edge. A valid that has been raised
// without a matching ready is held stable, with its payload, by its source.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   req_*             request channel from execute (op, addr, rs1 data,
//                     rs1==x0 flag, 5-bit immediate)
//   csr_rd_addr/data  combinational read port of the CSR file
//   csr_wr_*          write port of the CSR file
//   resp_*            response channel to writeback (old value, illegal)
//   dbg_state         current FSM state, for observation only
// -----------------------------------------------------------------------------
module core_csr_ctrl #(
   parameter int CSR_WIDTH  = 32,
   parameter int CSR_ADDR_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic [CSR_ADDR_W-1:0] req_addr,
   input  logic [CSR_WIDTH-1:0]  req_rs1_data,
   input  logic                  req_rs1_zero,
   input  logic [4:0]            req_zimm,
   output logic [CSR_ADDR_W-1:0] csr_rd_addr,
   input  logic [CSR_WIDTH-1:0]  csr_rd_data,
   output logic                  csr_wr_en,
   output logic [CSR_ADDR_W-1:0] csr_wr_addr,
   output logic [CSR_WIDTH-1:0]  csr_wr_data,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [CSR_WIDTH-1:0]  resp_rdata,
   output logic                  resp_illegal,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_next;

   logic [2:0]              r_op;
   logic [CSR_ADDR_W-1:0]   r_addr;
   logic [CSR_WIDTH-1:0]    r_operand;
   logic                    r_rs1_zero;
   logic [CSR_WIDTH-1:0]    r_rdata;
   logic [CSR_WIDTH-1:0]    r_wdata;
   logic                    r_illegal;

   logic [1:0]              w_kind;
   logic                    w_imm;
   logic                    w_wr_intent;
   logic                    w_read_only;
   logic                    w_illegal;
   logic                    w_do_write;
   logic [CSR_WIDTH-1:0]    w_new;

   // funct3[1:0] selects RW/RS/RC, funct3[2] selects the immediate form;
   // funct3[1:0]==0 covers both illegal encodings (0 and 4).
   assign w_kind = r_op[1:0];
   assign w_imm  = r_op[2];

   // For immediate ops the latched operand is the zero-extended zimm, so its
   // low five bits being nonzero is the same as zimm != 0.
   assign w_wr_intent = (w_kind == 2'd1) ||
                        ((w_kind != 2'd0) &&
                         (w_imm ? (r_operand[4:0] != 5'd0) : !r_rs1_zero));

   // Top two address bits 2'b11 mark the read-only CSR space.
   assign w_read_only = (r_addr[CSR_ADDR_W-1 -: 2] == 2'b11);
   assign w_illegal   = (w_kind == 2'd0) || (w_wr_intent && w_read_only);
   assign w_do_write  = w_wr_intent && !w_illegal;

   always_comb begin
      w_new = r_operand;
      case (w_kind)
         2'd2:    w_new = csr_rd_data | r_operand;
         2'd3:    w_new = csr_rd_data & ~r_operand;
         default: w_new = r_operand;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid)  w_next = S_READ;
         S_READ:  w_next = w_do_write ? S_WRITE : S_RESP;
         S_WRITE: w_next = S_RESP;
         S_RESP:  if (resp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_op       <= 3'd0;
         r_addr     <= '0;
         r_operand  <= '0;
         r_rs1_zero <= 1'b0;
         r_rdata    <= '0;
         r_wdata    <= '0;
         r_illegal  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && req_valid) begin
            r_op       <= req_op;
            r_addr     <= req_addr;
            r_operand  <= req_op[2] ? {{(CSR_WIDTH-5){1'b0}}, req_zimm}
                                    : req_rs1_data;
            r_rs1_zero <= req_rs1_zero;
         end
         if (r_state == S_READ) begin
            r_rdata   <= w_illegal ? '0 : csr_rd_data;
            r_wdata   <= w_new;
            r_illegal <= w_illegal;
         end
      end
   end

   assign req_ready    = (r_state == S_IDLE);
   assign csr_rd_addr  = r_addr;
   assign csr_wr_en    = (r_state == S_WRITE);
   assign csr_wr_addr  = r_addr;
   assign csr_wr_data  = r_wdata;
   assign resp_valid   = (r_state == S_RESP);
   assign resp_rdata   = r_rdata;
   assign resp_illegal = r_illegal;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_core_csr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_csr_ctrl
// Directed and randomized bench for core_csr_ctrl. A CSR-file model backs the
// DUT's read/write ports; a separate reference array holds the values the
// CSRs should contain, from which expected responses and writes are derived.
// -----------------------------------------------------------------------------
module tb_core_csr_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [11:0] req_addr;
   logic [31:0] req_rs1_data;
   logic        req_rs1_zero;
   logic [4:0]  req_zimm;
   logic [11:0] csr_rd_addr;
   logic [31:0] csr_rd_data;
   logic        csr_wr_en;
   logic [11:0] csr_wr_addr;
   logic [31:0] csr_wr_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_illegal;
   logic [1:0]  dbg_state;

   logic [31:0] csr_mem [0:4095];
   logic [31:0] ref_mem [0:4095];

   int n_vec;
   int n_err;

   core_csr_ctrl #(.CSR_WIDTH(32), .CSR_ADDR_W(12)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_rs1_data (req_rs1_data),
      .req_rs1_zero (req_rs1_zero),
      .req_zimm     (req_zimm),
      .csr_rd_addr  (csr_rd_addr),
      .csr_rd_data  (csr_rd_data),
      .csr_wr_en    (csr_wr_en),
      .csr_wr_addr  (csr_wr_addr),
      .csr_wr_data  (csr_wr_data),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_illegal (resp_illegal),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign csr_rd_data = csr_mem[csr_rd_addr];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
      csr_mem[a] = v;
      ref_mem[a] = v;
   endtask

   // Issue one request and follow it to the completed response handshake.
   // Entered and left just after a falling clock edge.
   task automatic run_req(input logic [2:0] op, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic rz,
                          input logic [4:0] zimm, input int hold);
      logic [31:0] operand, old, nv, exp_rdata;
      logic        wr, illegal, exp_wr;
      int          wr_seen, wk, rk;
      logic [11:0] wa;
      logic [31:0] wd;
      bit          got;

      // reference: decode the instruction from its architectural meaning
      operand = (op >= 3'd5) ? {27'd0, zimm} : rs1;
      old     = ref_mem[addr];
      case (op)
         3'd1, 3'd5: nv = operand;
         3'd2, 3'd6: nv = old | operand;
         3'd3, 3'd7: nv = old & ~operand;
         default:    nv = old;
      endcase
      wr = (op == 3'd1) || (op == 3'd5) ||
           (((op == 3'd2) || (op == 3'd3)) && !rz) ||
           (((op == 3'd6) || (op == 3'd7)) && (zimm != 5'd0));
      illegal   = (op == 3'd0) || (op == 3'd4) || (wr && (addr >= 12'hC00));
      exp_wr    = wr && !illegal;
      exp_rdata = illegal ? 32'd0 : old;

      req_op       = op;
      req_addr     = addr;
      req_rs1_data = rs1;
      req_rs1_zero = rz;
      req_zimm     = zimm;
      req_valid    = 1'b1;
      resp_ready   = (hold == 0);
      check("req_ready_idle", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;

      wr_seen = 0; wk = 0; rk = 0; got = 0; wa = '0; wd = '0;
      for (int k = 1; k <= 8 && !got; k++) begin
         @(negedge clk);
         if (csr_wr_en) begin
            wr_seen++;
            wa = csr_wr_addr;
            wd = csr_wr_data;
            wk = k;
            csr_mem[wa] = wd;
         end
         if (resp_valid) begin
            got = 1;
            rk  = k;
         end else begin
            check("req_ready_busy", {31'd0, req_ready}, 32'd0);
         end
      end
      check("resp_seen", {31'd0, got}, 32'd1);
      check("resp_latency", rk, exp_wr ? 32'd3 : 32'd2);
      check("write_count", wr_seen, {31'd0, exp_wr});
      if (exp_wr) begin
         check("write_cycle", wk, 32'd2);
         check("write_addr", {20'd0, wa}, {20'd0, addr});
         check("write_data", wd, nv);
         ref_mem[addr] = nv;
      end
      check("resp_rdata", resp_rdata, exp_rdata);
      check("resp_illegal", {31'd0, resp_illegal}, {31'd0, illegal});
      check("req_ready_resp", {31'd0, req_ready}, 32'd0);

      // stall in RESP while a new request waits upstream
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         req_op    = 3'd1;
         @(negedge clk);
         check("stall_valid", {31'd0, resp_valid}, 32'd1);
         check("stall_rdata", resp_rdata, exp_rdata);
         check("stall_illegal", {31'd0, resp_illegal}, {31'd0, illegal});
         check("stall_req_ready", {31'd0, req_ready}, 32'd0);
         check("stall_no_write", {31'd0, csr_wr_en}, 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      check("post_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("post_req_ready", {31'd0, req_ready}, 32'd1);
   endtask

   logic [11:0] addr_list [0:7];

   initial begin
      logic [11:0] ra;
      logic [31:0] keep;

      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_op = 3'd0;
      req_addr = '0;
      req_rs1_data = '0;
      req_rs1_zero = 1'b0;
      req_zimm = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < 4096; i++) set_csr(i[11:0], $urandom);
      set_csr(12'h340, 32'h11);
      set_csr(12'h300, 32'h3);
      set_csr(12'hC01, 32'h55);
      addr_list[0] = 12'h300; addr_list[1] = 12'h340; addr_list[2] = 12'h305;
      addr_list[3] = 12'hC00; addr_list[4] = 12'hC01; addr_list[5] = 12'hC02;
      addr_list[6] = 12'hF11; addr_list[7] = 12'h7C0;

      // reset values
      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_wr_en", {31'd0, csr_wr_en}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_illegal", {31'd0, resp_illegal}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_wr_addr", {20'd0, csr_wr_addr}, 32'd0);
      check("rst_wr_data", csr_wr_data, 32'd0);
      check("rst_rd_addr", {20'd0, csr_rd_addr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases
      run_req(3'd1, 12'h340, 32'hDEADBEEF, 1'b0, 5'd0, 0);  // CSRRW
      run_req(3'd2, 12'h300, 32'h8, 1'b0, 5'd0, 0);         // CSRRS -> 0xB
      run_req(3'd3, 12'h300, 32'h1, 1'b0, 5'd0, 0);         // CSRRC -> 0xA
      run_req(3'd6, 12'hC01, 32'h0, 1'b0, 5'd0, 0);         // CSRRSI zimm=0 read
      run_req(3'd6, 12'hC01, 32'h0, 1'b0, 5'd1, 0);         // CSRRSI to RO -> illegal
      run_req(3'd4, 12'h300, 32'h7, 1'b0, 5'd3, 0);         // illegal op
      run_req(3'd2, 12'h300, 32'h5, 1'b1, 5'd0, 0);         // rs1=x0 read only
      run_req(3'd7, 12'h300, 32'h0, 1'b0, 5'h1F, 0);        // CSRRCI, zero-extended
      run_req(3'd1, 12'h340, 32'h1234, 1'b0, 5'd0, 5);      // long stall in RESP

      // reset while READ of a CSRRW: the write must never happen
      keep = ref_mem[12'h305];
      req_op = 3'd1; req_addr = 12'h305; req_rs1_data = 32'hCAFE0001;
      req_rs1_zero = 1'b0; req_zimm = 5'd0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("mid_rst_wr_en", {31'd0, csr_wr_en}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_hold_wr_en", {31'd0, csr_wr_en}, 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_wr_en", {31'd0, csr_wr_en}, 32'd0);
      end
      check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("post_rst_csr", csr_mem[12'h305], keep);

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         ra = addr_list[$urandom_range(0, 7)];
         if ($urandom_range(0, 5) == 0) ra = 12'($urandom_range(0, 4095));
         run_req(3'($urandom_range(0, 7)), ra, $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
      end

      for (int a = 0; a < 8; a++) begin
         check("final_csr", csr_mem[addr_list[a]], ref_mem[addr_list[a]]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
